// File: rtl/char_write_arbiter.sv
// Shares the character-buffer write port between command writes and a fill engine; 1-cycle registered write latency.
// Under contention fill and command writes strictly alternate; a command is held off via cmd_ready for at most one cycle.
module char_write_arbiter #(
    parameter int ADDR_BITS = 11,
    parameter int BUF_SIZE  = 1920
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [7:0]           cmd_char,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 fill_start,
    input  logic [ADDR_BITS-1:0] fill_addr,
    input  logic [ADDR_BITS-1:0] fill_count,
    input  logic [7:0]           fill_char,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_char,
    output logic                 wr_wen
);

    typedef enum logic { IDLE, FILL } state_t;
    typedef enum logic { GNT_CMD, GNT_FILL } grant_t;

    localparam logic [ADDR_BITS-1:0] BUF_SZ   = ADDR_BITS'(BUF_SIZE);
    localparam logic [ADDR_BITS-1:0] BUF_LAST = ADDR_BITS'(BUF_SIZE - 1);

    state_t                 state_q, state_d;
    grant_t                 grant_q, grant_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [ADDR_BITS-1:0]   rem_q, rem_d;
    logic [7:0]             fchar_q, fchar_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]             wr_char_q, wr_char_d;
    logic                   wr_wen_q, wr_wen_d;
    logic                   done_q, done_d;

    assign cmd_ready = ~reset & ((state_q == IDLE) | (grant_q == GNT_FILL));
    assign fill_busy = (state_q == FILL);
    assign fill_done = done_q;
    assign wr_addr   = wr_addr_q;
    assign wr_char   = wr_char_q;
    assign wr_wen    = wr_wen_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        fchar_d   = fchar_q;
        wr_addr_d = wr_addr_q;
        wr_char_d = wr_char_q;
        wr_wen_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    wr_wen_d  = 1'b1;
                    wr_addr_d = cmd_addr;
                    wr_char_d = cmd_char;
                end
                if (fill_start) begin
                    if (fill_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FILL;
                        // Grant history set to CMD so the fill owns the first FILL cycle.
                        grant_d = GNT_CMD;
                        ptr_d   = (fill_addr >= BUF_SZ) ? '0 : fill_addr;
                        rem_d   = (fill_count > BUF_SZ) ? BUF_SZ : fill_count;
                        fchar_d = fill_char;
                    end
                end
            end
            FILL: begin
                if (cmd_valid && grant_q == GNT_FILL) begin
                    wr_wen_d  = 1'b1;
                    wr_addr_d = cmd_addr;
                    wr_char_d = cmd_char;
                    grant_d   = GNT_CMD;
                end else begin
                    wr_wen_d  = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_char_d = fchar_q;
                    grant_d   = GNT_FILL;
                    ptr_d     = (ptr_q == BUF_LAST) ? '0 : ptr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == ADDR_BITS'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= GNT_CMD;
            ptr_q     <= '0;
            rem_q     <= '0;
            fchar_q   <= '0;
            wr_addr_q <= '0;
            wr_char_q <= '0;
            wr_wen_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            fchar_q   <= fchar_d;
            wr_addr_q <= wr_addr_d;
            wr_char_q <= wr_char_d;
            wr_wen_q  <= wr_wen_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_char_write_arbiter.sv
// Directed bench for char_write_arbiter: expected writes are queued as stimulus is driven
// and checked in order against every wr_wen cycle.
module tb_char_write_arbiter;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_char;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          fill_start;
    logic [AW-1:0] fill_addr;
    logic [AW-1:0] fill_count;
    logic [7:0]    fill_char;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_char;
    logic          wr_wen;

    char_write_arbiter #(.ADDR_BITS(AW), .BUF_SIZE(1920)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_addr   (cmd_addr),
        .cmd_char   (cmd_char),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .fill_start (fill_start),
        .fill_addr  (fill_addr),
        .fill_count (fill_count),
        .fill_char  (fill_char),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .wr_wen     (wr_wen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    c;
        logic          d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bare_pending = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int c, input logic d);
        exp_t e;
        e.a = AW'(a);
        e.c = 8'(c);
        e.d = d;
        sb.push_back(e);
    endtask

    // Every write must match the head of the scoreboard; a done pulse without a write must be expected.
    always @(negedge clk) begin
        if (wr_wen === 1'b1) begin
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.a));
                check("wr_char", 32'(wr_char), 32'(mon_e.c));
                check("wr_done", 32'(fill_done), 32'(mon_e.d));
            end
        end else if (fill_done === 1'b1) begin
            check("bare_done_expected", 32'(bare_pending), 32'd1);
            bare_pending = 0;
        end
    end

    task automatic start_fill(input int a, input int n, input int ch);
        @(posedge clk); #1;
        fill_start = 1'b1;
        fill_addr  = AW'(a);
        fill_count = AW'(n);
        fill_char  = 8'(ch);
        @(posedge clk); #1;
        fill_start = 1'b0;
    endtask

    task automatic drain(input int budget, input string tag);
        int left;
        left = budget;
        while (sb.size() != 0 && left > 0) begin
            @(negedge clk); #1;
            left--;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int n_acc;
        logic acc;

        reset      = 1'b1;
        cmd_addr   = '0;
        cmd_char   = '0;
        cmd_valid  = 1'b0;
        fill_start = 1'b0;
        fill_addr  = '0;
        fill_count = '0;
        fill_char  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_wen", 32'(wr_wen), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_fill_busy", 32'(fill_busy), 32'd0);
        check("rst_fill_done", 32'(fill_done), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_char", 32'(wr_char), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (20) @(negedge clk);
        check("idle_fill_busy", 32'(fill_busy), 32'd0);

        // single command write in IDLE
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 11'd5; cmd_char = 8'h41;
        push(5, 8'h41, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain(5, "cmd_drain");
        repeat (3) @(negedge clk);

        // wrapping fill, no commands
        for (int i = 0; i < 15; i++) push((1910 + i) % 1920, 8'h20, i == 14);
        start_fill(1910, 15, 8'h20);
        busy_cnt = 0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
            if (fill_busy) busy_cnt++;
        end
        check("wrap_drain", 32'(sb.size()), 32'd0);
        check("wrap_busy_cycles", 32'(busy_cnt), 32'd15);
        check("wrap_busy_low", 32'(fill_busy), 32'd0);
        repeat (3) @(negedge clk);

        // contention: fill first, then strict alternation with a held command stream
        for (int i = 0; i < 10; i++) begin
            push(i, 8'h2E, i == 9);
            if (i < 9) push(100 + i, 100 + i, 1'b0);
        end
        start_fill(0, 10, 8'h2E);
        cmd_valid = 1'b1; cmd_addr = 11'd100; cmd_char = 8'd100;
        n_acc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                cmd_addr = cmd_addr + 1'b1;
                cmd_char = cmd_char + 1'b1;
            end
            if (!fill_busy) break;
        end
        cmd_valid = 1'b0;
        drain(5, "contend_drain");
        check("contend_cmd_accepts", 32'(n_acc), 32'd9);
        repeat (3) @(negedge clk);

        // zero-count fill: done pulse only
        bare_pending = 1;
        start_fill(30, 0, 8'h55);
        @(negedge clk);
        check("zero_busy", 32'(fill_busy), 32'd0);
        repeat (3) @(negedge clk);
        check("zero_done_seen", 32'(bare_pending), 32'd0);

        // oversize count clamps to the full buffer
        for (int i = 0; i < 1920; i++) push(i, 8'h2A, i == 1919);
        start_fill(0, 2047, 8'h2A);
        drain(2100, "full_drain");
        repeat (4) @(negedge clk);

        // out-of-range start address restarts at 0
        for (int i = 0; i < 3; i++) push(i, 8'h2D, i == 2);
        start_fill(2000, 3, 8'h2D);
        drain(20, "oob_drain");
        repeat (3) @(negedge clk);

        // simultaneous command and fill start in IDLE
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 11'd7; cmd_char = 8'h78;
        fill_start = 1'b1; fill_addr = 11'd20; fill_count = 11'd2; fill_char = 8'h79;
        push(7, 8'h78, 1'b0);
        push(20, 8'h79, 1'b0);
        push(21, 8'h79, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; fill_start = 1'b0;
        drain(10, "both_drain");
        repeat (3) @(negedge clk);

        // second fill_start during a fill is ignored
        for (int i = 0; i < 5; i++) push(50 + i, 8'h61, i == 4);
        start_fill(50, 5, 8'h61);
        @(posedge clk); #1;
        fill_start = 1'b1; fill_addr = 11'd300; fill_count = 11'd4; fill_char = 8'h62;
        @(posedge clk); #1;
        fill_start = 1'b0;
        drain(20, "refill_drain");
        repeat (4) @(negedge clk);

        // reset after three writes of a ten-cell fill
        for (int i = 0; i < 3; i++) push(10 + i, 8'h5A, 1'b0);
        start_fill(10, 10, 8'h5A);
        drain(20, "abort_drain");
        reset = 1'b1;
        @(negedge clk);
        check("abort_wr_wen", 32'(wr_wen), 32'd0);
        check("abort_fill_busy", 32'(fill_busy), 32'd0);
        check("abort_fill_done", 32'(fill_done), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_idle_busy", 32'(fill_busy), 32'd0);
        check("abort_idle_ready", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
